// File: rtl/arb2_sel_if.sv
// Purpose: request/grant/select bundle between two requesters and arb2_sel.
// Latency: none (wires only).
// Backpressure: requesters hold reqN until gntN drops; grants are the only flow control.
// Signals: req0/req1 requests; lock (only with ARB2_LOCK_EN) holds the current grant;
//          sel mux select; gnt0/gnt1 one-hot grants; busy = any grant; burst_cnt 0-based
//          length of the current grant.
interface arb2_sel_if;
    logic       req0;
    logic       req1;
`ifdef ARB2_LOCK_EN
    logic       lock;
`endif
    logic       sel;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic [7:0] burst_cnt;

    // Arbiter side.
    modport slave (
        input  req0, req1,
`ifdef ARB2_LOCK_EN
        input  lock,
`endif
        output sel, gnt0, gnt1, busy, burst_cnt
    );

    // Requester side.
    modport master (
        output req0, req1,
`ifdef ARB2_LOCK_EN
        output lock,
`endif
        input  sel, gnt0, gnt1, busy, burst_cnt
    );
endinterface

// File: rtl/arb2_sel.sv
// Purpose: two-requester round-robin arbiter driving the select of a 1-bit 2:1 mux.
// Latency: one cycle from sampled request (or release) to grant change; all outputs registered.
// Backpressure: a grant is bounded to BURST_MAX cycles while the other side waits.
// Ports: clk, rst (async, active-high), bus (arb2_sel_if.slave: req0/req1 in,
//        sel/gnt0/gnt1/busy/burst_cnt out).
// Option: define ARB2_LOCK_EN to add bus.lock, which suppresses burst pre-emption.
module arb2_sel #(
    parameter int unsigned BURST_MAX = 8    // 1..255
) (
    input  logic       clk,
    input  logic       rst,
    arb2_sel_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic       last_q,  last_d;     // most recently served requester
    logic       sel_q,   sel_d;
    logic       gnt0_q,  gnt0_d;
    logic       gnt1_q,  gnt1_d;
    logic [7:0] cnt_q,   cnt_d;

    logic       lock_w;
    logic       enter0, enter1, go_idle;

`ifdef ARB2_LOCK_EN
    assign lock_w = bus.lock;
`else
    assign lock_w = 1'b0;
`endif

    always_comb begin
        enter0  = 1'b0;
        enter1  = 1'b0;
        go_idle = 1'b0;
        cnt_d   = cnt_q;
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;

        case (state_q)
            IDLE: begin
                // On a tie, favour whoever was not served last.
                if (bus.req0 && (!bus.req1 || last_q)) enter0 = 1'b1;
                else if (bus.req1)                     enter1 = 1'b1;
            end
            G0: begin
                if (!bus.req0) begin
                    if (bus.req1) enter1 = 1'b1;
                    else          go_idle = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // Burst exhausted: hand over if the other side waits,
                    // otherwise start a fresh burst. Lock pins the count.
                    if (lock_w)        cnt_d  = cnt_q;
                    else if (bus.req1) enter1 = 1'b1;
                    else               cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            G1: begin
                if (!bus.req1) begin
                    if (bus.req0) enter0 = 1'b1;
                    else          go_idle = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    if (lock_w)        cnt_d  = cnt_q;
                    else if (bus.req0) enter0 = 1'b1;
                    else               cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (enter0) begin
            state_d = G0;
            last_d  = 1'b0;
            sel_d   = 1'b0;
            cnt_d   = '0;
        end else if (enter1) begin
            state_d = G1;
            last_d  = 1'b1;
            sel_d   = 1'b1;
            cnt_d   = '0;
        end else if (go_idle) begin
            // sel is left alone so the mux output stays steady between grants.
            state_d = IDLE;
            cnt_d   = '0;
        end

        gnt0_d = (state_d == G0);
        gnt1_d = (state_d == G1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;     // requester 0 wins the first tie
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = gnt0_q | gnt1_q;
    assign bus.burst_cnt = cnt_q;

endmodule

// File: tb/tb_arb2_sel.sv
// Purpose: randomized + directed bench for arb2_sel with a scoreboard-fed monitor.
// Latency: expectations queued at each sampling edge, compared 1 time unit later.
// Backpressure: n/a; two DUTs (BURST_MAX 4 and 1) share the same request stimulus.
module tb_arb2_sel;

    logic clk;
    logic rst;
    logic req0_s, req1_s, lock_s;

    int checks = 0;
    int errors = 0;

    arb2_sel_if ifc0 ();
    arb2_sel_if ifc1 ();

    assign ifc0.req0 = req0_s;
    assign ifc0.req1 = req1_s;
    assign ifc1.req0 = req0_s;
    assign ifc1.req1 = req1_s;
`ifdef ARB2_LOCK_EN
    assign ifc0.lock = lock_s;
    assign ifc1.lock = lock_s;
`endif

    arb2_sel #(.BURST_MAX(4)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    arb2_sel #(.BURST_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt0, gnt1, sel, busy, burst_cnt[7:0]}.
    logic [11:0] q0[$];
    logic [11:0] q1[$];

    // Reference model: owner -1 means nobody holds the lane; run is the
    // number of cycles already granted in the current burst.
    int owner[2];
    int run[2];
    int last[2];
    int selm[2];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got g0g1/sel/busy=%b cnt=%0d, expected %b cnt=%0d",
                     name, $time, act[11:8], act[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic give(input int i, input int k);
        owner[i] = k;
        last[i]  = k;
        selm[i]  = k;
        run[i]   = 0;
    endtask

    task automatic model_step(input int i, input int bm, input bit r0, input bit r1, input bit lk);
        bit rq[2];
        int k;
        logic [11:0] e;
        rq[0] = r0;
        rq[1] = r1;
        if (owner[i] < 0) begin
            if (r0 && r1) give(i, 1 - last[i]);
            else if (r0)  give(i, 0);
            else if (r1)  give(i, 1);
        end else begin
            k = owner[i];
            if (!rq[k]) begin
                if (rq[1-k]) give(i, 1 - k);
                else begin owner[i] = -1; run[i] = 0; end
            end else if (run[i] == bm - 1) begin
                if (lk)           run[i] = bm - 1;
                else if (rq[1-k]) give(i, 1 - k);
                else              run[i] = 0;
            end else begin
                run[i] = run[i] + 1;
            end
        end
        e = {owner[i] == 0, owner[i] == 1, selm[i] == 1, owner[i] >= 0, 8'(run[i])};
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic logic [11:0] pk0();
        return {ifc0.gnt0, ifc0.gnt1, ifc0.sel, ifc0.busy, ifc0.burst_cnt};
    endfunction

    function automatic logic [11:0] pk1();
        return {ifc1.gnt0, ifc1.gnt1, ifc1.sel, ifc1.busy, ifc1.burst_cnt};
    endfunction

    // Scoreboard producer.
    always @(posedge clk) begin
        bit lk;
        lk = 1'b0;
`ifdef ARB2_LOCK_EN
        lk = lock_s;
`endif
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                owner[i] = -1; run[i] = 0; last[i] = 1; selm[i] = 0;
            end
        end else begin
            model_step(0, 4, req0_s, req1_s, lk);
            model_step(1, 1, req0_s, req1_s, lk);
        end
    end

    // Monitor: compares whatever the model queued for this edge.
    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (q0.size() > 0) begin e = q0.pop_front(); check("bm4_outputs", pk0(), e); end
        if (q1.size() > 0) begin e = q1.pop_front(); check("bm1_outputs", pk1(), e); end
    end

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req0_s = 1'b0; req1_s = 1'b0; lock_s = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_bm4", pk0(), 12'h000);
        check("reset_bm1", pk1(), 12'h000);
        cycles(2);
        rst = 1'b0;
        cycles(2);

        // Lone requester 0 for 5 cycles, then quiet.
        req0_s = 1'b1; cycles(5);
        req0_s = 1'b0; cycles(3);

        // Contention for 16 cycles.
        req0_s = 1'b1; req1_s = 1'b1; cycles(16);
        req0_s = 1'b0; req1_s = 1'b0; cycles(3);

        // Lone requester 1 for 10 cycles (burst_cnt wraps).
        req1_s = 1'b1; cycles(10);
        req1_s = 1'b0; cycles(3);

        // Direct hand-over: release G0 at burst_cnt 2 while req1 waits.
        req0_s = 1'b1; cycles(3);
        req1_s = 1'b1; req0_s = 1'b0; cycles(4);
        req1_s = 1'b0; cycles(3);

`ifdef ARB2_LOCK_EN
        // Lock held through G0 with both requesting, then released.
        req0_s = 1'b1; req1_s = 1'b1; lock_s = 1'b1; cycles(8);
        lock_s = 1'b0; cycles(6);
        req0_s = 1'b0; req1_s = 1'b0; cycles(3);
`endif

        // Pulses between edges must go unseen.
        for (int p = 0; p < 3; p++) begin
            #1 req0_s = 1'b1;
            #2 req0_s = 1'b0;
            @(negedge clk);
        end

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) req0_s = ~req0_s;
            if ($urandom_range(0, 3) == 0) req1_s = ~req1_s;
`ifdef ARB2_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock_s = ~lock_s;
`endif
            @(negedge clk);
        end
        req0_s = 1'b0; req1_s = 1'b0; lock_s = 1'b0;
        cycles(3);

        // Reset in the middle of a G1 burst at burst_cnt 3.
        req1_s = 1'b1; cycles(4);
        check("g1_before_reset", pk0(), {4'b0111, 8'd3});
        rst = 1'b1;
        #1;
        check("async_reset_bm4", pk0(), 12'h000);
        check("async_reset_bm1", pk1(), 12'h000);
        req1_s = 1'b0;
        cycles(2);
        rst = 1'b0; req0_s = 1'b1; req1_s = 1'b1;
        @(posedge clk);
        #2;
        check("first_tie_after_reset", pk0(), {4'b1001, 8'd0});
        cycles(6);
        req0_s = 1'b0; req1_s = 1'b0;
        cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
